// File: rtl/setn_release_pkg.sv
// Shared state encoding and width helpers for the SETN release sequencer.
package setn_release_pkg;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3,
    ST_SOFT    = 3'd4
  } state_e;

  // One extra bit beyond the largest limit, so a count never wraps.
  function automatic int cnt_width(input int hold, input int stagger);
    int m;
    m = (hold > stagger) ? hold : stagger;
    return $clog2(m) + 1;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rn_sync2.sv
// Two-flop reset synchroniser: asserts asynchronously with RN, deasserts on the
// second CLK rising edge after RN rises.
module rn_sync2 (
  input  logic CLK,
  input  logic RN,
  output logic RN_SYNC
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= 1'b1;
      r_sync <= r_meta;
    end
  end

  assign RN_SYNC = r_sync;

endmodule

// File: rtl/setn_release_seq.sv
// Drives active-low SETN for negative-edge set-flop banks: hold all groups in
// set after reset, then release them bit 0 first with a fixed stagger.
module setn_release_seq
  import setn_release_pkg::*;
#(
  parameter int N_GROUPS    = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGGER     = 2
) (
  input  logic                CLK,
  input  logic                RN,
  input  logic                SOFT_REQ,
  output logic                SOFT_ACK,
  output logic [N_GROUPS-1:0] SETN,
  output logic                READY,
  output logic [2:0]          STATE_DBG
);

  localparam int CW = cnt_width(HOLD_CYCLES, STAGGER);
  localparam int GW = idx_width(N_GROUPS);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAG_LAST  = CW'(STAGGER - 1);
  localparam logic [GW-1:0] GIDX_PENULT = GW'(N_GROUPS - 2);

  if (N_GROUPS < 1 || HOLD_CYCLES < 1 || STAGGER < 1) begin : g_bad_param
    $error("setn_release_seq: N_GROUPS, HOLD_CYCLES and STAGGER must all be >= 1");
  end

  logic                w_rn_sync;
  state_e              r_state, w_state_n;
  logic [CW-1:0]       r_cnt, w_cnt_n;
  logic [GW-1:0]       r_gidx, w_gidx_n;
  logic [N_GROUPS-1:0] r_setn, w_setn_n;
  logic                r_ready, w_ready_n;
  logic                r_ack, w_ack_n;
  logic [N_GROUPS-1:0] w_lsb;

  rn_sync2 u_rn_sync (
    .CLK     (CLK),
    .RN      (RN),
    .RN_SYNC (w_rn_sync)
  );

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      r_state <= ST_RESET;
      r_cnt   <= '0;
      r_gidx  <= '0;
      r_setn  <= '0;
      r_ready <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_gidx  <= w_gidx_n;
      r_setn  <= w_setn_n;
      r_ready <= w_ready_n;
      r_ack   <= w_ack_n;
    end
  end

  // SETN is a thermometer: each release shifts one more 1 in from bit 0.
  always_comb begin
    w_lsb    = '0;
    w_lsb[0] = 1'b1;
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_gidx_n  = r_gidx;
    w_setn_n  = r_setn;
    w_ready_n = r_ready;
    w_ack_n   = r_ack;
    case (r_state)
      ST_RESET: begin
        if (w_rn_sync) begin
          w_state_n = ST_HOLD;
          w_cnt_n   = '0;
        end
      end
      ST_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_cnt_n  = '0;
          w_gidx_n = '0;
          w_setn_n = r_setn | w_lsb;
          if (N_GROUPS == 1) begin
            w_ready_n = 1'b1;
            w_state_n = ST_RUN;
          end else begin
            w_state_n = ST_RELEASE;
          end
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      ST_RELEASE: begin
        if (r_cnt == STAG_LAST) begin
          w_cnt_n  = '0;
          w_gidx_n = r_gidx + GW'(1);
          w_setn_n = (r_setn << 1) | w_lsb;
          if (r_gidx == GIDX_PENULT) begin
            w_ready_n = 1'b1;
            w_state_n = ST_RUN;
          end
        end else begin
          w_cnt_n = r_cnt + CW'(1);
        end
      end
      ST_RUN: begin
        if (SOFT_REQ) begin
          w_state_n = ST_SOFT;
          w_setn_n  = '0;
          w_ready_n = 1'b0;
          w_ack_n   = 1'b1;
        end
      end
      ST_SOFT: begin
        if (!SOFT_REQ) begin
          w_ack_n   = 1'b0;
          w_state_n = ST_HOLD;
          w_cnt_n   = '0;
        end
      end
      default: w_state_n = ST_RESET;
    endcase
  end

  assign SETN      = r_setn;
  assign READY     = r_ready;
  assign SOFT_ACK  = r_ack;
  assign STATE_DBG = r_state;

endmodule

// File: tb/tb_setn_release_seq.sv
// Bench for setn_release_seq: directed timing steps plus random RN/SOFT_REQ
// traffic checked against a release-time reference model.
module tb_setn_release_seq;

  localparam int N = 4;
  localparam int H = 8;
  localparam int S = 2;

  logic         CLK = 1'b0;
  logic         RN = 1'b0;
  logic         SOFT_REQ = 1'b0;
  logic         SOFT_ACK;
  logic [N-1:0] SETN;
  logic         READY;
  logic [2:0]   STATE_DBG;

  logic         soft_req1 = 1'b0;
  logic         soft_ack1;
  logic [0:0]   setn1;
  logic         ready1;
  logic [2:0]   state1;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: edges since sync start, time since HOLD entry, soft phase.
  int m_sync = 0;
  bit m_act = 0;
  int m_t = 0;
  bit m_soft = 0;

  always #5 CLK = ~CLK;

  setn_release_seq #(.N_GROUPS(N), .HOLD_CYCLES(H), .STAGGER(S)) dut (
    .CLK(CLK), .RN(RN), .SOFT_REQ(SOFT_REQ), .SOFT_ACK(SOFT_ACK),
    .SETN(SETN), .READY(READY), .STATE_DBG(STATE_DBG)
  );

  setn_release_seq #(.N_GROUPS(1), .HOLD_CYCLES(1), .STAGGER(1)) dut1 (
    .CLK(CLK), .RN(RN), .SOFT_REQ(soft_req1), .SOFT_ACK(soft_ack1),
    .SETN(setn1), .READY(ready1), .STATE_DBG(state1)
  );

  function automatic int released(input int t);
    int r;
    if (t < H) return 0;
    r = 1 + (t - H) / S;
    return (r > N) ? N : r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sync = 0;
    m_act  = 0;
    m_t    = 0;
    m_soft = 0;
  endtask

  task automatic model_edge();
    if (RN) begin
      if (!m_act) begin
        m_sync++;
        if (m_sync >= 3) begin
          m_act = 1;
          m_t   = 0;
        end
      end else if (m_soft) begin
        if (!SOFT_REQ) begin
          m_soft = 0;
          m_t    = 0;
        end
      end else if (released(m_t) == N && SOFT_REQ) begin
        m_soft = 1;
      end else if (m_t < 100000) begin
        m_t++;
      end
    end
  endtask

  task automatic check_all();
    int r;
    logic [N-1:0] e_setn;
    logic         e_ready;
    logic [2:0]   e_state;
    if (!m_act || m_soft) begin
      e_setn  = '0;
      e_ready = 1'b0;
      e_state = !m_act ? 3'd0 : 3'd4;
    end else begin
      r       = released(m_t);
      e_setn  = N'((1 << r) - 1);
      e_ready = (r == N);
      e_state = (m_t < H) ? 3'd1 : (r == N) ? 3'd3 : 3'd2;
    end
    chk("setn", 32'(SETN), 32'(e_setn));
    chk("ready", 32'(READY), 32'(e_ready));
    chk("soft_ack", 32'(SOFT_ACK), 32'(m_soft));
    chk("state_dbg", 32'(STATE_DBG), 32'(e_state));
    chk("inv_ready_all_ones", 32'(READY && (SETN != '1)), 32'd0);
    chk("inv_ack_in_soft", 32'(SOFT_ACK && (STATE_DBG != 3'd4)), 32'd0);
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_all();
  endtask

  task automatic rn_drop();
    RN = 1'b0;
    #1;
    model_reset();
    check_all();
  endtask

  task automatic rn_rise();
    RN = 1'b1;
    model_reset();
  endtask

  initial begin
    int r;
    // Reset held low
    @(negedge CLK);
    #1;
    check_all();
    chk("dut1_reset_setn", 32'(setn1), 32'd0);
    @(negedge CLK);

    // Nominal sequence; RN rises before e1
    rn_rise();
    for (int e = 1; e <= 17; e++) begin
      step();
      if (e == 3) begin
        chk("dut1_e3_state", 32'(state1), 32'd1);
        chk("dut1_e3_setn", 32'(setn1), 32'd0);
      end
      if (e == 4) begin
        chk("dut1_e4_setn", 32'(setn1), 32'd1);
        chk("dut1_e4_ready", 32'(ready1), 32'd1);
        chk("dut1_e4_state", 32'(state1), 32'd3);
      end
      if (e == 10) chk("e10_setn", 32'(SETN), 32'h0);
      if (e == 11) chk("e11_setn", 32'(SETN), 32'h1);
      if (e == 13) chk("e13_setn", 32'(SETN), 32'h3);
      if (e == 15) chk("e15_setn", 32'(SETN), 32'h7);
      if (e == 16) chk("e16_ready", 32'(READY), 32'd0);
      if (e == 17) chk("e17_ready", 32'(READY), 32'd1);
    end

    // Soft handshake from RUN
    SOFT_REQ = 1'b1;
    step();
    chk("soft_r_ack", 32'(SOFT_ACK), 32'd1);
    chk("soft_r_state", 32'(STATE_DBG), 32'd4);
    repeat (5) step();
    SOFT_REQ = 1'b0;
    step();
    chk("soft_s_ack", 32'(SOFT_ACK), 32'd0);
    for (int k = 1; k <= 14; k++) begin
      step();
      if (k == 7) chk("soft_s7_setn", 32'(SETN), 32'h0);
      if (k == 8) chk("soft_s8_setn", 32'(SETN), 32'h1);
      if (k == 13) chk("soft_s13_ready", 32'(READY), 32'd0);
      if (k == 14) chk("soft_s14_ready", 32'(READY), 32'd1);
    end

    // RN dropped mid-release at e14, then full replay
    rn_drop();
    @(negedge CLK);
    rn_rise();
    for (int e = 1; e <= 14; e++) step();
    chk("mid_release_setn_before", 32'(SETN), 32'h3);
    rn_drop();
    chk("mid_release_setn", 32'(SETN), 32'h0);
    chk("mid_release_state", 32'(STATE_DBG), 32'd0);
    @(negedge CLK);
    rn_rise();

    // SOFT_REQ raised during HOLD is served on the first RUN edge
    for (int e = 1; e <= 18; e++) begin
      step();
      if (e == 4) SOFT_REQ = 1'b1;
      if (e == 11) chk("replay_e11_setn", 32'(SETN), 32'h1);
      if (e == 17) chk("early_req_e17_ack", 32'(SOFT_ACK), 32'd0);
      if (e == 18) chk("early_req_e18_ack", 32'(SOFT_ACK), 32'd1);
    end
    SOFT_REQ = 1'b0;
    step();

    // Random RN pulses, glitches and SOFT_REQ traffic
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        RN = 1'b0;
        #2;
        model_reset();
        check_all();
        RN = 1'b1;
      end else if (r < 4) begin
        rn_drop();
        repeat ($urandom_range(1, 3)) step();
        rn_rise();
      end else if (r < 20) begin
        SOFT_REQ = ~SOFT_REQ;
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    n_err++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "timeout");
  end

endmodule
